// File: rtl/descrambler_ctrl_if.sv
// descrambler_ctrl_if: upstream bit stream, descrambler pins and status of descrambler_ctrl.
// slave is the controller's view, master is the environment's view.
interface descrambler_ctrl_if #(
   parameter int LEN_W     = 12,
   parameter int SEED_BITS = 7
);
   logic                 DescCtrl_Start;
   logic [LEN_W-1:0]     DescCtrl_Length;
   logic                 DescCtrl_DataIN;
   logic                 DescCtrl_DataIN_VALID;
   logic                 Desc_Reset;
   logic [SEED_BITS-1:0] Desc_InitialState;
   logic                 Desc_DataIN;
   logic                 Desc_DataIN_VALID;
   logic                 Desc_DataOUT;
   logic                 Desc_DataVALID;
   logic                 DescCtrl_DataOUT;
   logic                 DescCtrl_DataVALID;
   logic                 DescCtrl_Busy;
   logic                 DescCtrl_Done;
   logic                 DescCtrl_ServiceErr;
   logic                 DescCtrl_LengthErr;
   modport slave (
      input  DescCtrl_Start, DescCtrl_Length, DescCtrl_DataIN, DescCtrl_DataIN_VALID,
             Desc_DataOUT, Desc_DataVALID,
      output Desc_Reset, Desc_InitialState, Desc_DataIN, Desc_DataIN_VALID,
             DescCtrl_DataOUT, DescCtrl_DataVALID, DescCtrl_Busy, DescCtrl_Done,
             DescCtrl_ServiceErr, DescCtrl_LengthErr
   );
   modport master (
      output DescCtrl_Start, DescCtrl_Length, DescCtrl_DataIN, DescCtrl_DataIN_VALID,
             Desc_DataOUT, Desc_DataVALID,
      input  Desc_Reset, Desc_InitialState, Desc_DataIN, Desc_DataIN_VALID,
             DescCtrl_DataOUT, DescCtrl_DataVALID, DescCtrl_Busy, DescCtrl_Done,
             DescCtrl_ServiceErr, DescCtrl_LengthErr
   );
endinterface

// File: rtl/descrambler_ctrl.sv
// descrambler_ctrl: 802.11a receive descrambler sequencer (seed recovery, SERVICE drop, PSDU pass).
// Define DESC_CTRL_SERVICE_CHECK_EN to build the SERVICE bit 7..15 zero check driving ServiceErr.
module descrambler_ctrl #(
   parameter int LEN_W        = 12,
   parameter int SERVICE_BITS = 16,
   parameter int SEED_BITS    = 7,
   parameter int CNT_W        = 16
) (
   input logic               clock,
   input logic               DescCtrl_Reset,
   descrambler_ctrl_if.slave bus
);
   localparam int SVC_OUT = SERVICE_BITS - SEED_BITS;
   localparam int SCW     = $clog2(SEED_BITS);
   typedef enum logic [1:0] {IDLE, SEED, SERVICE, PSDU} state_t;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     psdu_tgt_q, psdu_tgt_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, in_tgt;
   logic [SEED_BITS-1:0] seed_q, seed_d, init_q, init_d;
   logic [SCW-1:0]       seed_cnt_q, seed_cnt_d;
   logic desc_rst_q, desc_rst_d, din_q, din_d, din_vld_q, din_vld_d;
   logic dout_q, dout_d, dvld_q, dvld_d, busy_q, busy_d, done_q, done_d;
   logic serr_q, serr_d, lerr_q, lerr_d;
   logic active, accept, seed_shift, seed_last, fwd, svc, emit;
   always_comb begin
      active     = state_q == SERVICE || state_q == PSDU;
      in_tgt     = CNT_W'(SVC_OUT) + psdu_tgt_q;
      accept     = state_q == IDLE && bus.DescCtrl_Start && bus.DescCtrl_Length != '0;
      seed_shift = state_q == SEED && bus.DescCtrl_DataIN_VALID;
      seed_last  = seed_shift && seed_cnt_q == SCW'(SEED_BITS - 1);
      fwd        = active && bus.DescCtrl_DataIN_VALID && in_cnt_q < in_tgt;
      // output count runs SERVICE bits first, then PSDU bits, against the same target as input
      svc        = active && bus.Desc_DataVALID && out_cnt_q < CNT_W'(SVC_OUT);
      emit       = active && bus.Desc_DataVALID && !svc && out_cnt_q < in_tgt;
      psdu_tgt_d = accept ? CNT_W'({bus.DescCtrl_Length[LEN_W-1:0], 3'b000}) : psdu_tgt_q;
      in_cnt_d   = accept ? '0 : in_cnt_q + CNT_W'(fwd);
      out_cnt_d  = accept ? '0 : out_cnt_q + CNT_W'(svc || emit);
      seed_cnt_d = accept ? '0 : seed_cnt_q + SCW'(seed_shift);
      seed_d     = seed_shift ? {seed_q[SEED_BITS-2:0], bus.DescCtrl_DataIN} : seed_q;
      init_d     = seed_last ? seed_d : init_q;
      desc_rst_d = !active;
      din_vld_d  = fwd;
      din_d      = fwd && bus.DescCtrl_DataIN;
      dvld_d     = emit;
      dout_d     = emit && bus.Desc_DataOUT;
      done_d     = emit && out_cnt_q == in_tgt - CNT_W'(1);
      lerr_d     = state_q == IDLE && bus.DescCtrl_Start && bus.DescCtrl_Length == '0;
`ifdef DESC_CTRL_SERVICE_CHECK_EN
      serr_d     = accept ? 1'b0 : serr_q || (svc && bus.Desc_DataOUT);
`else
      serr_d     = 1'b0;
`endif
      state_d    = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SEED;
         SEED:    if (seed_last) state_d = SERVICE;
         SERVICE: if (svc && out_cnt_q == CNT_W'(SVC_OUT - 1)) state_d = PSDU;
         default: if (done_q) state_d = IDLE;
      endcase
      busy_d     = state_d != IDLE;
   end
   always_ff @(posedge clock or posedge DescCtrl_Reset) begin
      if (DescCtrl_Reset) begin
         state_q    <= IDLE;
         psdu_tgt_q <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         seed_q     <= '0;
         seed_cnt_q <= '0;
         init_q     <= '0;
         desc_rst_q <= 1'b1;
         din_q      <= 1'b0;
         din_vld_q  <= 1'b0;
         dout_q     <= 1'b0;
         dvld_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         serr_q     <= 1'b0;
         lerr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         psdu_tgt_q <= psdu_tgt_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         seed_q     <= seed_d;
         seed_cnt_q <= seed_cnt_d;
         init_q     <= init_d;
         desc_rst_q <= desc_rst_d;
         din_q      <= din_d;
         din_vld_q  <= din_vld_d;
         dout_q     <= dout_d;
         dvld_q     <= dvld_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         serr_q     <= serr_d;
         lerr_q     <= lerr_d;
      end
   end
   assign bus.Desc_Reset          = desc_rst_q;
   assign bus.Desc_InitialState   = init_q;
   assign bus.Desc_DataIN         = din_q;
   assign bus.Desc_DataIN_VALID   = din_vld_q;
   assign bus.DescCtrl_DataOUT    = dout_q;
   assign bus.DescCtrl_DataVALID  = dvld_q;
   assign bus.DescCtrl_Busy       = busy_q;
   assign bus.DescCtrl_Done       = done_q;
   assign bus.DescCtrl_ServiceErr = serr_q;
   assign bus.DescCtrl_LengthErr  = lerr_q;
endmodule

// File: tb/tb_descrambler_ctrl.sv
// tb_descrambler_ctrl: scoreboard bench; frames are scrambled by a reference transmit scrambler,
// a behavioural descrambler sits on the Desc_* pins, a monitor checks every PSDU output bit.
`timescale 1ns/1ps
module tb_descrambler_ctrl;
`ifdef DESC_CTRL_SERVICE_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   typedef struct packed {logic b; int t; logic last;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   exp_t sb[$];
   logic [7:0] psdu_q[$];
   logic [6:0] dst;
   descrambler_ctrl_if #(.LEN_W(12), .SEED_BITS(7)) bus ();
   descrambler_ctrl dut (.clock(clk), .DescCtrl_Reset(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction
   // downstream descrambler: x^7+x^4+1, loads the seed while reset is high, 1-cycle latency
   always @(posedge clk) begin
      if (bus.Desc_Reset) begin
         dst <= bus.Desc_InitialState;
         bus.Desc_DataVALID <= 1'b0;
         bus.Desc_DataOUT <= 1'b0;
      end else begin
         bus.Desc_DataVALID <= bus.Desc_DataIN_VALID;
         if (bus.Desc_DataIN_VALID) begin
            bus.Desc_DataOUT <= bus.Desc_DataIN ^ dst[6] ^ dst[3];
            dst <= {dst[5:0], dst[6] ^ dst[3]};
         end
      end
   end
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.DescCtrl_Done) begin
            done_cnt++;
            chk("done_qualified", bus.DescCtrl_DataVALID, 1);
         end
         if (bus.DescCtrl_DataVALID) begin
            chk("output_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("out_bit", bus.DescCtrl_DataOUT, e.b);
               chk("out_time", cyc, e.t);
               chk("done_flag", bus.DescCtrl_Done, e.last);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // gap: 0 back-to-back, 1 alternating, 2 random; noise pulses Start in PSDU and in the Done cycle
   task automatic run_frame(input logic [6:0] seed, input logic [8:0] svc_hi, input int gap,
                            input bit noise, input bit start_valid, input int abort_at);
      bit pt[$];
      bit tx[$];
      logic [6:0] s, exp_seed;
      logic fb;
      int len, n, last;
      len = psdu_q.size();
      s = seed;
      exp_seed = '0;
      for (int i = 0; i < 7; i++) pt.push_back(1'b0);
      for (int i = 0; i < 9; i++) pt.push_back(svc_hi[i]);
      foreach (psdu_q[k]) for (int i = 0; i < 8; i++) pt.push_back(psdu_q[k][i]);
      for (int i = 0; i < 6; i++) pt.push_back(1'b0);
      for (int i = 0; i < 10; i++) pt.push_back(1'($urandom_range(0, 1)));
      n = pt.size();
      last = 16 + 8 * len - 1;
      foreach (pt[i]) begin
         fb = s[6] ^ s[3];
         tx.push_back(pt[i] ^ fb);
         s = {s[5:0], fb};
         if (i == 6) exp_seed = s;
      end
      done_cnt = 0;
      bus.DescCtrl_Start = 1'b1;
      bus.DescCtrl_Length = 12'(len);
      bus.DescCtrl_DataIN_VALID = start_valid;
      bus.DescCtrl_DataIN = ~tx[0];
      tick();
      bus.DescCtrl_Start = 1'b0;
      bus.DescCtrl_DataIN_VALID = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == abort_at) begin
            #2 rst = 1'b1;
            #1;
            chk("abort_desc_reset", bus.Desc_Reset, 1);
            chk("abort_outputs_zero", {bus.Desc_InitialState, bus.Desc_DataIN, bus.Desc_DataIN_VALID,
                bus.DescCtrl_DataOUT, bus.DescCtrl_DataVALID, bus.DescCtrl_Busy, bus.DescCtrl_Done,
                bus.DescCtrl_ServiceErr, bus.DescCtrl_LengthErr}, 0);
            sb.delete();
            bus.DescCtrl_DataIN_VALID = 1'b0;
            tick();
            rst = 1'b0;
            tick();
            return;
         end
         if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
            bus.DescCtrl_DataIN_VALID = 1'b0;
            tick();
         end
         bus.DescCtrl_DataIN_VALID = 1'b1;
         bus.DescCtrl_DataIN = tx[i];
         bus.DescCtrl_Start = noise && (i == 20 || i == last + 3);
         bus.DescCtrl_Length = 12'd1;
         if (i >= 16 && i <= last) begin
            exp_t e;
            e.b = pt[i];
            e.t = cyc + 3;
            e.last = i == last;
            sb.push_back(e);
         end
         tick();
      end
      bus.DescCtrl_DataIN_VALID = 1'b0;
      bus.DescCtrl_Start = 1'b0;
      for (int w = 0; w < 40 && (sb.size() != 0 || bus.DescCtrl_Busy); w++) tick();
      repeat (3) tick();
      chk("frame_drained", sb.size(), 0);
      chk("busy_after_frame", bus.DescCtrl_Busy, 0);
      chk("done_count", done_cnt, 1);
      chk("initial_state", bus.Desc_InitialState, exp_seed);
      chk("service_err", bus.DescCtrl_ServiceErr, CHK_EN && svc_hi != 0);
   endtask
   initial begin
      bus.DescCtrl_Start = 1'b0;
      bus.DescCtrl_Length = '0;
      bus.DescCtrl_DataIN = 1'b0;
      bus.DescCtrl_DataIN_VALID = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("reset_desc_reset", bus.Desc_Reset, 1);
      chk("reset_outputs_zero", {bus.Desc_InitialState, bus.Desc_DataIN, bus.Desc_DataIN_VALID,
          bus.DescCtrl_DataOUT, bus.DescCtrl_DataVALID, bus.DescCtrl_Busy, bus.DescCtrl_Done,
          bus.DescCtrl_ServiceErr, bus.DescCtrl_LengthErr}, 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      psdu_q = '{8'hA5, 8'h3C};
      run_frame(7'b1011101, 9'h000, 0, 1'b0, 1'b1, -1);
      run_frame(7'b1011101, 9'b000001000, 0, 1'b0, 1'b0, -1);
      bus.DescCtrl_Start = 1'b1;
      bus.DescCtrl_Length = '0;
      tick();
      bus.DescCtrl_Start = 1'b0;
      chk("length_err_pulse", bus.DescCtrl_LengthErr, 1);
      chk("length_err_busy", bus.DescCtrl_Busy, 0);
      for (int i = 0; i < 5; i++) begin
         bus.DescCtrl_DataIN_VALID = 1'b1;
         bus.DescCtrl_DataIN = 1'($urandom_range(0, 1));
         tick();
         chk("length_err_no_fwd", {bus.Desc_DataIN_VALID, bus.DescCtrl_Busy, bus.DescCtrl_LengthErr}, 0);
      end
      bus.DescCtrl_DataIN_VALID = 1'b0;
      tick();
      psdu_q = '{8'($urandom)};
      run_frame(7'($urandom_range(1, 127)), 9'h000, 1, 1'b0, 1'b0, -1);
      psdu_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(7'h5A, 9'h000, 0, 1'b0, 1'b0, 21);
      psdu_q = '{8'hC3};
      run_frame(7'h2B, 9'h000, 0, 1'b0, 1'b0, -1);
      psdu_q = '{8'h0F, 8'hF0};
      run_frame(7'h7F, 9'h000, 0, 1'b1, 1'b0, -1);
      for (int f = 0; f < 4; f++) begin
         psdu_q.delete();
         for (int k = 0; k < int'($urandom_range(1, 5)); k++) psdu_q.push_back(8'($urandom));
         run_frame(7'($urandom_range(1, 127)), (f == 2) ? 9'h100 : 9'h000, 2, 1'b0, 1'b0, -1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
